if_id_skid: RTL and testbench
=============================

Name: if_id_skid

Overview:
- Parametrised IF→ID pipeline stage, successor to the plain flop-through IF/ID latch.
- Carries {pc, instruction} from fetch to decode using a valid/ready handshake.
- A 2-entry skid buffer keeps `in_ready` a pure register output, so there is no combinational ready path back into fetch.
- Supports flush (branch redirect) with bubble injection; decode always sees a NOP when nothing valid is presented.

Parameters:
- XLEN, 32, width of pc
- ILEN, 32, width of instruction word
- NOP_INSN, 32'h00000013, bubble instruction (ADDI x0,x0,0) driven on out_is when out_valid=0; width ILEN
- RST_PC, 32'h00000000, value of out_pc at reset/after flush; width XLEN

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  fetch presents an entry
- in_ready  output  1  stage can accept; registered
- in_pc  input  XLEN  fetch pc
- in_is  input  ILEN  fetch instruction
- out_valid  output  1  decode entry valid; registered
- out_ready  input  1  decode accepts
- out_pc  output  XLEN  entry pc; registered
- out_is  output  ILEN  entry instruction; registered
- occ  output  2  entries held (0..2); registered

Behaviour:
- **Handshake:** in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. A transfer occurs only on fire; data may change only after fire.
- **Storage:** main register (drives out_*) plus skid register; state derived from {main_v, skid_v}.
- **States:** EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
- **Registered outputs:** in_ready = ~skid_v (registered, 1 in EMPTY/ONE, 0 in TWO); out_valid = main_v.
- **Reset (priority 1):**
  - out_valid=0, out_pc=RST_PC, out_is=NOP_INSN, occ=0, skid cleared; in_ready=1 from the first cycle after reset.
  - Inputs are ignored in the reset cycle.
  - Reset asserted mid-transfer discards everything; no entry survives.
- **Flush (priority 2):**
  - Next state EMPTY; out_pc=RST_PC, out_is=NOP_INSN.
  - A simultaneous in_fire entry is dropped, and a simultaneous out_fire still counts as consumed by decode.
  - in_ready is 1 the following cycle.
- **Transitions** (no rst/flush):
  - EMPTY: in_fire → ONE, main<=in.
  - ONE:
    - in_fire & out_fire → ONE, main<=in (back-to-back, full throughput).
    - in_fire & ~out_fire → TWO, skid<=in.
    - ~in_fire & out_fire → EMPTY, main<=bubble.
    - else hold.
  - TWO (in_ready=0, in_valid ignored): out_fire → ONE, main<=skid, skid cleared; else hold.
- **Bubble:** whenever main_v=0, out_is=NOP_INSN and out_pc=RST_PC. Decode may rely on this and ignore out_valid.
- **Latency and throughput:** 1 cycle from in_fire to out_valid in EMPTY. Sustained throughput is 1 entry/cycle with out_ready=1. Ordering is strictly FIFO.
- **Stability:** out_* remain stable while out_valid & ~out_ready.
- **No pass-through:** no combinational path from any input to any output.

Decomposition:
- Shared package (cpu_defs):
  - XLEN/ILEN defaults
  - NOP_INSN constant
  - RST_PC constant
  - 2-bit occupancy state encoding (ST_EMPTY=0, ST_ONE=1, ST_TWO=2)
- One natural sub-module: pipe_skid_core.
  - Generic DW-wide 2-entry skid buffer with flush and bubble value.
  - if_id_skid instantiates it with DW=XLEN+ILEN and concatenated {pc, is}; later id_ex/ex_mem stages reuse it.

Test Plan:
- Reset: hold rst=1 two cycles with in_valid=1, in_pc=0x100 → out_valid=0, out_is=0x00000013, out_pc=0, occ=0; in_ready=1 the cycle after rst drops.
- Streaming: out_ready=1, feed pc 0x0,0x4,0x8,0xC with instructions 0x11,0x22,0x33,0x44 on consecutive cycles → same sequence on out_* one cycle later, one per cycle, occ stays 1.
- Backpressure: out_ready=0 after first entry (pc 0x0), fetch offers 0x4 then 0x8 → occ=2 and in_ready=0 after 0x4; 0x8 held at input; out_pc stays 0x0. Raise out_ready → outputs 0x0,0x4,0x8 in order, none lost or duplicated.
- Flush in TWO: occ=2 (0x10, 0x14) with in_valid=1 pc 0x18, assert flush one cycle → next cycle occ=0, out_valid=0, out_is=NOP, in_ready=1; 0x10/0x14/0x18 never appear.
- Flush with simultaneous out_fire in ONE: occ=1 (pc 0x20), out_ready=1, flush=1 → 0x20 counted consumed; next cycle EMPTY with bubble outputs.
- Random valid/ready with occasional flush, checked against a scoreboard queue → FIFO order preserved; out_* stable whenever out_valid & ~out_ready; occ always matches the model.

Source files
------------

// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the pipeline-stage registers (IF/ID, ID/EX, EX/MEM).
//   - Default datapath widths (pc and instruction word).
//   - Bubble instruction and the pc shown with it.
//   - Occupancy/state encoding of the 2-entry skid buffer.
//   - Helper that builds the {pc, instruction} bubble word for a stage.
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam int DEF_XLEN = 32;
    localparam int DEF_ILEN = 32;

    // ADDI x0,x0,0 -- architecturally a no-op, so decode can run it blindly.
    localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] DEF_RST_PC   = 32'h0000_0000;

    // The encoding doubles as the occupancy count, so occ is the state value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // Bubble word for a {pc, insn} payload at the default widths.
    function automatic logic [DEF_XLEN+DEF_ILEN-1:0] if_id_bubble();
        return {DEF_RST_PC, DEF_NOP_INSN};
    endfunction

endpackage

// File: rtl/pipe_skid_core.sv
// -----------------------------------------------------------------------------
// pipe_skid_core
//   Generic DW-wide 2-entry skid buffer between two pipeline stages.
//   The main register drives the output; the skid register catches the one
//   entry that can arrive in the cycle after the consumer stalls, which is what
//   lets in_ready be a plain flop with no combinational path from out_ready.
//   Every output is a flop; nothing passes straight from an input.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      discard everything held plus any entry accepted this cycle
//   in_valid   producer offers in_data
//   in_ready   buffer can accept (registered, low only when both entries full)
//   in_data    producer payload
//   out_valid  out_data is a real entry (registered)
//   out_ready  consumer accepts out_data
//   out_data   head entry, or BUBBLE when empty (registered)
//   occ        number of entries held, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipe_skid_core
    import cpu_defs::*;
#(
    parameter int             DW     = 64,
    parameter logic [DW-1:0]  BUBBLE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    occ_state_e    state;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_fire;
    logic          out_fire;

    // in_ready is already 0 in ST_TWO, so in_valid is naturally ignored there.
    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_q    <= BUBBLE;
            skid_q    <= BUBBLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occ       <= ST_EMPTY;
        end else if (flush) begin
            // An entry accepted this cycle is dropped; one consumed this
            // cycle has already been taken by the consumer, so both simply
            // vanish along with everything held.
            state     <= ST_EMPTY;
            main_q    <= BUBBLE;
            skid_q    <= BUBBLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occ       <= ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state     <= ST_ONE;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        occ       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Streaming: head leaves, new entry takes its place.
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Consumer stalled while we were still ready: skid.
                        state    <= ST_TWO;
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        occ      <= ST_TWO;
                    end else if (out_fire) begin
                        state     <= ST_EMPTY;
                        main_q    <= BUBBLE;
                        out_valid <= 1'b0;
                        occ       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state    <= ST_ONE;
                        main_q   <= skid_q;
                        skid_q   <= BUBBLE;
                        in_ready <= 1'b1;
                        occ      <= ST_ONE;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty buffer.
                    state     <= ST_EMPTY;
                    main_q    <= BUBBLE;
                    skid_q    <= BUBBLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occ       <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
//   IF->ID pipeline stage. Carries {pc, instruction} from fetch to decode over
//   a valid/ready handshake through a 2-entry skid buffer, so in_ready is a
//   register and fetch never sees a combinational ready from decode. When no
//   entry is presented decode sees pc=RST_PC and a NOP, so it may ignore
//   out_valid if convenient. flush (branch redirect) empties the stage.
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   flush                    drop held and incoming entries this cycle
//   in_valid/in_ready        fetch handshake (in_ready registered)
//   in_pc, in_is             fetch pc and instruction
//   out_valid/out_ready      decode handshake (out_valid registered)
//   out_pc, out_is           entry to decode, bubble when empty (registered)
//   occ                      entries held, 0..2 (registered)
// -----------------------------------------------------------------------------
module if_id_skid
    import cpu_defs::*;
#(
    parameter int               XLEN     = DEF_XLEN,
    parameter int               ILEN     = DEF_ILEN,
    parameter logic [ILEN-1:0]  NOP_INSN = ILEN'(DEF_NOP_INSN),
    parameter logic [XLEN-1:0]  RST_PC   = XLEN'(DEF_RST_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_is,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_is,
    output logic [1:0]      occ
);

    localparam int DW = XLEN + ILEN;

    logic [DW-1:0] out_data;

    pipe_skid_core #(
        .DW     (DW),
        .BUBBLE ({RST_PC, NOP_INSN})
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_is}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    assign out_pc = out_data[DW-1:ILEN];
    assign out_is = out_data[ILEN-1:0];

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_is, out_pc, out_is;
    logic [1:0]  occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_is     (in_is),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_is    (out_is),
        .occ       (occ)
    );

    typedef struct {
        logic        r, f, v;
        logic [31:0] pc, is;
        logic        ordy;
        logic        ev;
        logic [31:0] epc, eis;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(input logic r, f, v, input logic [31:0] pc, is,
                                 input logic ordy, ev, input logic [31:0] epc, eis,
                                 input logic [1:0] eocc, input logic erdy);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.pc = pc; t.is = is; t.ordy = ordy;
        t.ev = ev; t.epc = epc; t.eis = eis; t.eocc = eocc; t.erdy = erdy;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, f, v, input logic [31:0] pc, is, input logic ordy);
        rst = r; flush = f; in_valid = v; in_pc = pc; in_is = is; out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc, eis,
                           input logic [1:0] eocc, input logic erdy);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_pc"},    out_pc,         epc);
        chk({tag, ".out_is"},    out_is,         eis);
        chk({tag, ".occ"},       32'(occ),       32'(eocc));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(erdy));
    endtask

    // Reference: the stage is a FIFO of depth 2. Accept when fewer than two
    // entries are held, present the oldest entry, empty on reset/flush.
    logic [63:0] q[$];

    task automatic chk_model(input string tag);
        if (q.size() == 0) chk_all(tag, 1'b0, RPC, NOP, 2'd0, 1'b1);
        else chk_all(tag, 1'b1, q[0][63:32], q[0][31:0], 2'(q.size()), q.size() < 2);
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        // reset held two cycles with fetch offering 0x100
        addv(1,0,1,32'h100,32'hDEAD, 0, 0,RPC,NOP,0,1);
        addv(1,0,1,32'h100,32'hDEAD, 0, 0,RPC,NOP,0,1);
        // streaming, out_ready=1
        addv(0,0,1,32'h0,32'h11, 1, 1,32'h0,32'h11,1,1);
        addv(0,0,1,32'h4,32'h22, 1, 1,32'h4,32'h22,1,1);
        addv(0,0,1,32'h8,32'h33, 1, 1,32'h8,32'h33,1,1);
        addv(0,0,1,32'hC,32'h44, 1, 1,32'hC,32'h44,1,1);
        addv(0,0,0,32'h0,32'h0,  1, 0,RPC,NOP,0,1);
        // backpressure
        addv(0,0,1,32'h0,32'hA0, 0, 1,32'h0,32'hA0,1,1);
        addv(0,0,1,32'h4,32'hA4, 0, 1,32'h0,32'hA0,2,0);
        addv(0,0,1,32'h8,32'hA8, 0, 1,32'h0,32'hA0,2,0);
        addv(0,0,1,32'h8,32'hA8, 1, 1,32'h4,32'hA4,1,1);
        addv(0,0,1,32'h8,32'hA8, 1, 1,32'h8,32'hA8,1,1);
        addv(0,0,0,32'h0,32'h0,  1, 0,RPC,NOP,0,1);
        // flush while full, fetch offering 0x18
        addv(0,0,1,32'h10,32'hB0, 0, 1,32'h10,32'hB0,1,1);
        addv(0,0,1,32'h14,32'hB4, 0, 1,32'h10,32'hB0,2,0);
        addv(0,1,1,32'h18,32'hB8, 0, 0,RPC,NOP,0,1);
        addv(0,0,0,32'h18,32'hB8, 1, 0,RPC,NOP,0,1);

        drive(1,0,0,0,0,0);
        tick;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].pc, tbl[i].is, tbl[i].ordy);
            tick;
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eis,
                    tbl[i].eocc, tbl[i].erdy);
        end

        // ---------------- flush with simultaneous out_fire in ONE ----------------
        drive(0,0,1,32'h20,32'hC0,0); tick;
        chk_all("f1.load", 1, 32'h20, 32'hC0, 1, 1);
        drive(0,1,0,32'h0,32'h0,1);   tick;
        chk_all("f1.flush", 0, RPC, NOP, 0, 1);
        drive(0,0,0,32'h0,32'h0,1);   tick;
        chk_all("f1.after", 0, RPC, NOP, 0, 1);

        // ---------------- reset while full, fetch still offering ----------------
        drive(0,0,1,32'h40,32'hD0,0); tick;
        drive(0,0,1,32'h44,32'hD4,0); tick;
        chk_all("r2.full", 1, 32'h40, 32'hD0, 2, 0);
        drive(1,0,1,32'h48,32'hD8,1); tick;
        chk_all("r2.rst", 0, RPC, NOP, 0, 1);
        drive(0,0,0,32'h0,32'h0,1);   tick;
        chk_all("r2.after", 0, RPC, NOP, 0, 1);

        // ---------------- randomized run against the FIFO model ----------------
        begin
            logic [31:0] npc, nis, ppc, pis;
            logic        r, f, v, o, inf, outf, hold;
            npc = 32'h1000;
            nis = $urandom;
            q.delete();
            for (int i = 0; i < 3000; i++) begin
                r = ($urandom_range(0, 199) == 0);
                f = ($urandom_range(0, 99) < 3);
                v = ($urandom_range(0, 99) < 70);
                o = ($urandom_range(0, 99) < 55);
                drive(r, f, v, npc, nis, o);
                inf  = !r && v && (q.size() < 2);
                outf = !r && (q.size() > 0) && o;
                hold = !r && !f && (q.size() > 0) && !o;
                ppc  = out_pc;
                pis  = out_is;
                tick;
                if (r || f) q.delete();
                else begin
                    if (outf) void'(q.pop_front());
                    if (inf)  q.push_back({npc, nis});
                end
                if (inf) begin
                    npc = npc + 32'd4;
                    nis = $urandom;
                end
                chk_model($sformatf("rnd%0d", i));
                if (hold) begin
                    chk($sformatf("rnd%0d.hold_pc", i), out_pc, ppc);
                    chk($sformatf("rnd%0d.hold_is", i), out_is, pis);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
